// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare branch predictor: history width, PHT
// counter encoding and a saturating 32-bit increment.
package common;

   localparam int GHR_SIZE = 5;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } pht_state_type;

   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      logic [31:0] result;
      if (value == 32'hFFFF_FFFF) begin
         result = value;
      end else begin
         result = value + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter; holds when
// not enabled.
module sat_counter2
   import common::*;
(
   input  logic          en,
   input  logic          up,
   input  pht_state_type cur,
   output pht_state_type nxt
);

   // Step one state toward strongly-taken or strongly-not-taken, clamping at the ends
   always_comb begin
      nxt = cur;
      if (en) begin
         case (cur)
            SNT:     nxt = up ? WNT : SNT;
            WNT:     nxt = up ? WT  : SNT;
            WT:      nxt = up ? ST  : WNT;
            ST:      nxt = up ? ST  : WT;
            default: nxt = WNT;
         endcase
      end else begin
         nxt = cur;
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch predictor: PC xor global history indexes a table
// of 2-bit counters; history is speculatively shifted and repaired on mispredict.
module gshare_predictor #(
   parameter int GHR_SIZE = common::GHR_SIZE
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                fetch_valid,
   input  logic                fetch_stall,
   input  logic [31:0]         fetch_pc,
   input  logic                fetch_is_branch,
   output logic                pred_taken,
   output logic [GHR_SIZE-1:0] pred_ghr,
   output logic [GHR_SIZE-1:0] pred_index,
   input  logic                res_valid,
   input  logic                res_is_branch,
   input  logic                res_taken,
   input  logic                res_mispredict,
   input  logic [GHR_SIZE-1:0] res_ghr,
   input  logic [GHR_SIZE-1:0] res_index,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
);
   import common::*;

   localparam int DEPTH = 1 << GHR_SIZE;

   pht_state_type       pht_r [DEPTH];
   pht_state_type       pht_nxt_s;
   logic [GHR_SIZE-1:0] ghr_r;
   logic [31:0]         branches_r;
   logic [31:0]         mispredicts_r;
   logic                upd_s;
   logic                repair_s;
   logic                shift_s;
   logic                unused_bits_s;

   assign upd_s    = res_valid && res_is_branch;
   assign repair_s = upd_s && res_mispredict;
   assign shift_s  = fetch_valid && fetch_is_branch && !fetch_stall;

   assign pred_index       = fetch_pc[GHR_SIZE:1] ^ ghr_r;
   assign pred_ghr         = ghr_r;
   assign stat_branches    = branches_r;
   assign stat_mispredicts = mispredicts_r;
   assign unused_bits_s    = ^{fetch_pc[31:GHR_SIZE+1], fetch_pc[0], res_ghr[GHR_SIZE-1]};

   // Lookup reads the table before any same-cycle update lands
   always_comb begin
      pred_taken = 1'b0;
      if (fetch_is_branch) begin
         pred_taken = pht_r[pred_index][1];
      end else begin
         pred_taken = 1'b0;
      end
   end

   sat_counter2 u_sat_counter2 (
      .en  (upd_s),
      .up  (res_taken),
      .cur (pht_r[res_index]),
      .nxt (pht_nxt_s)
   );

   // Pattern history table: train the resolved entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pht_r[i] <= WNT;
         end
      end else if (upd_s) begin
         pht_r[res_index] <= pht_nxt_s;
      end
   end

   // Global history: repair from the resolved branch wins over the fetch shift
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ghr_r <= '0;
      end else if (repair_s) begin
         ghr_r <= {res_ghr[GHR_SIZE-2:0], res_taken};
      end else if (shift_s) begin
         ghr_r <= {ghr_r[GHR_SIZE-2:0], pred_taken};
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         branches_r    <= 32'd0;
         mispredicts_r <= 32'd0;
      end else begin
         if (upd_s) begin
            branches_r <= sat_inc32(branches_r);
         end
         if (repair_s) begin
            mispredicts_r <= sat_inc32(mispredicts_r);
         end
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomised and directed bench for gshare_predictor against an array-based
// reference model of the predictor's rules.
module tb_gshare_predictor;

   logic        clk;
   logic        reset_n;
   logic        fetch_valid;
   logic        fetch_stall;
   logic [31:0] fetch_pc;
   logic        fetch_is_branch;
   logic        pred_taken;
   logic [4:0]  pred_ghr;
   logic [4:0]  pred_index;
   logic        res_valid;
   logic        res_is_branch;
   logic        res_taken;
   logic        res_mispredict;
   logic [4:0]  res_ghr;
   logic [4:0]  res_index;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;

   int     n_vec;
   int     n_err;
   int     pht_m [32];
   int     ghr_m;
   longint br_m;
   longint mis_m;

   gshare_predictor #(.GHR_SIZE(5)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .fetch_valid      (fetch_valid),
      .fetch_stall      (fetch_stall),
      .fetch_pc         (fetch_pc),
      .fetch_is_branch  (fetch_is_branch),
      .pred_taken       (pred_taken),
      .pred_ghr         (pred_ghr),
      .pred_index       (pred_index),
      .res_valid        (res_valid),
      .res_is_branch    (res_is_branch),
      .res_taken        (res_taken),
      .res_mispredict   (res_mispredict),
      .res_ghr          (res_ghr),
      .res_index        (res_index),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) pht_m[i] = 1;
      ghr_m = 0;
      br_m  = 0;
      mis_m = 0;
   endtask

   task automatic clear_inputs();
      fetch_valid = 1'b0; fetch_stall = 1'b0; fetch_pc = 32'd0; fetch_is_branch = 1'b0;
      res_valid = 1'b0; res_is_branch = 1'b0; res_taken = 1'b0; res_mispredict = 1'b0;
      res_ghr = 5'd0; res_index = 5'd0;
   endtask

   // One clock: drive, check lookup against model, clock, advance model, check stats
   task automatic cycle(input logic fv, input logic fs, input logic [31:0] pc, input logic fb,
                        input logic rv, input logic rb, input logic rt, input logic rm,
                        input logic [4:0] rg, input logic [4:0] ri);
      int exp_idx;
      int exp_pred;
      @(negedge clk);
      fetch_valid = fv; fetch_stall = fs; fetch_pc = pc; fetch_is_branch = fb;
      res_valid = rv; res_is_branch = rb; res_taken = rt; res_mispredict = rm;
      res_ghr = rg; res_index = ri;
      #1;
      exp_idx  = ((pc >> 1) % 32) ^ ghr_m;
      exp_pred = (fb && pht_m[exp_idx] >= 2) ? 1 : 0;
      check_val("pred_index", {27'd0, pred_index}, exp_idx);
      check_val("pred_taken", {31'd0, pred_taken}, exp_pred);
      check_val("pred_ghr", {27'd0, pred_ghr}, ghr_m);
      @(posedge clk);
      if (rv && rb) begin
         if (br_m < 64'hFFFF_FFFF) br_m++;
         if (rt) pht_m[ri] = (pht_m[ri] == 3) ? 3 : pht_m[ri] + 1;
         else    pht_m[ri] = (pht_m[ri] == 0) ? 0 : pht_m[ri] - 1;
         if (rm && mis_m < 64'hFFFF_FFFF) mis_m++;
      end
      if (rv && rb && rm)          ghr_m = (int'(rg) * 2 + int'(rt)) % 32;
      else if (fv && fb && !fs)    ghr_m = (ghr_m * 2 + exp_pred) % 32;
      #1;
      check_val("stat_branches", stat_branches, br_m[31:0]);
      check_val("stat_mispredicts", stat_mispredicts, mis_m[31:0]);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      clear_inputs();
      reset_n = 1'b0;
      fetch_pc = 32'h40;
      fetch_is_branch = 1'b1;
      #2;
      check_val("rst_branches", stat_branches, 32'd0);
      check_val("rst_mispredicts", stat_mispredicts, 32'd0);
      check_val("rst_ghr", {27'd0, pred_ghr}, 32'd0);
      check_val("rst_pred", {31'd0, pred_taken}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Branch at 0x40 with empty history
      cycle(1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      check_val("pc40_index", {27'd0, pred_index}, 32'h0);
      // Train index 5 taken twice, then look it up, then saturate
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd5);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd5);
      cycle(1'b0, 1'b0, 32'h0A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd5);
      check_val("idx5_strong", {31'd0, pred_taken}, 32'd1);
      // Three fetched branches predicted 0,0,1
      cycle(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      cycle(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      cycle(1'b1, 1'b0, 32'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      check_val("ghr_001", {27'd0, pred_ghr}, 32'h01);
      // Repair history to zero, then repeat with the third fetch stalled
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd31);
      cycle(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      cycle(1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      cycle(1'b1, 1'b1, 32'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      check_val("ghr_stall", {27'd0, pred_ghr}, 32'h00);
      // Repair and predicted-taken shift in the same cycle
      cycle(1'b1, 1'b0, 32'h0A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b10110, 5'd3);
      check_val("ghr_repair", {27'd0, pred_ghr}, 32'h0C);
      // Same-cycle lookup and update at index 0x0A (pc[5:1]=6 xor ghr 0x0C)
      cycle(1'b0, 1'b0, 32'h0C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd10);
      cycle(1'b0, 1'b0, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      check_val("rbw_next", {31'd0, pred_taken}, 32'd1);
      // jal/jalr resolution must not touch history or stats
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         cycle(1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom),
               1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom),
               1'($urandom_range(0, 3) == 0), 5'($urandom), 5'($urandom));
      end

      // Four branches, two mispredicted, then reset mid-cycle with an update in flight
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd1);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd1);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd1);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd1);
      @(negedge clk);
      res_valid = 1'b1; res_is_branch = 1'b1; res_taken = 1'b1; res_index = 5'd1;
      #2;
      reset_n = 1'b0;
      #1;
      check_val("mid_rst_branches", stat_branches, 32'd0);
      check_val("mid_rst_mispredicts", stat_mispredicts, 32'd0);
      check_val("mid_rst_ghr", {27'd0, pred_ghr}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         fetch_is_branch = 1'b1;
         fetch_pc = 32'(i) << 1;
         #1;
         check_val("mid_rst_pht", {31'd0, pred_taken}, 32'd0);
      end
      model_reset();
      @(negedge clk);
      clear_inputs();
      reset_n = 1'b1;
      cycle(1'b0, 1'b0, 32'h02, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1);
      cycle(1'b0, 1'b0, 32'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
      for (int n = 0; n < 100; n++) begin
         cycle(1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), 5'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter GHR_SIZE, default common::GHR_SIZE (5): history width, index width; PHT depth 2**GHR_SIZE.
REQ-002 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port fetch_valid  in  1  fetch stage holds a valid instruction this cycle.
REQ-005 SHALL have port fetch_stall  in  1  fetch stage stalled; no history advance.
REQ-006 SHALL have port fetch_pc  in  32  PC of the fetched instruction.
REQ-007 SHALL have port fetch_is_branch  in  1  predecode: opcode is conditional branch (B_TYPE).
REQ-008 SHALL have port pred_taken  out  1  prediction, carried as if_id.branch_prediction.
REQ-009 SHALL have port pred_ghr  out  GHR_SIZE  history used for lookup, carried as if_id.ghr.
REQ-010 SHALL have port pred_index  out  GHR_SIZE  PHT index used, carried as if_id.shared_index.
REQ-011 SHALL have port res_valid  in  1  MEM-stage resolution valid.
REQ-012 SHALL have port res_is_branch  in  1  resolved instruction is a conditional branch.
REQ-013 SHALL have port res_taken  in  1  actual outcome (BEU is_taken_branch).
REQ-014 SHALL have port res_mispredict  in  1  outcome differs from carried prediction.
REQ-015 SHALL have port res_ghr  in  GHR_SIZE  ghr carried in ex_mem.
REQ-016 SHALL have port res_index  in  GHR_SIZE  shared_index carried in ex_mem.
REQ-017 SHALL have ports stat_branches, stat_mispredicts  out  32 each  resolved-branch / misprediction counters.

Function
REQ-018 SHALL compute pred_index = fetch_pc[GHR_SIZE:1] XOR ghr_q (bit 1 included for compressed instructions); combinational, zero latency.
REQ-019 SHALL drive pred_taken = PHT[pred_index][1] when fetch_is_branch, else 0; pred_ghr = ghr_q.
REQ-020 SHALL hold PHT as 2-bit saturating counters: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-021 SHALL, on res_valid && res_is_branch, increment PHT[res_index] if res_taken (saturate at 11), else decrement (saturate at 00), effective next edge.
REQ-022 SHALL advance speculative history on fetch_valid && fetch_is_branch && !fetch_stall: ghr_q <= {ghr_q[GHR_SIZE-2:0], pred_taken}.
REQ-023 SHALL repair history on res_valid && res_is_branch && res_mispredict: ghr_q <= {res_ghr[GHR_SIZE-2:0], res_taken}.
REQ-024 SHALL give repair (REQ-023) priority over speculative shift (REQ-022) in the same cycle; the fetched instruction is flushed.
REQ-025 SHALL return the pre-update PHT value for a same-cycle lookup and update to the same index (read-before-write).
REQ-026 SHALL ignore res_mispredict and res_taken when res_is_branch = 0 (jal/jalr handled by BEU, no PHT or history effect).
REQ-027 SHALL increment stat_branches per resolved branch, stat_mispredicts per mispredicted branch; both saturate at 32'hFFFF_FFFF.

Reset
REQ-028 SHALL, while reset_n = 0, immediately force every PHT entry to 01, ghr_q to 0, both stat counters to 0; pred_taken thus 0.
REQ-029 SHALL discard any in-flight update when reset asserts mid-cycle; first update acts on the first rising edge after release.

Structure
REQ-030 SHALL take GHR_SIZE and a new enum pht_state_type {SNT,WNT,WT,ST} from package common; no local copies.
REQ-031 SHALL use one sub-module, sat_counter2 (2-bit saturating up/down with enable), instanced per PHT entry or as a shared next-state function.

Verification
REQ-032 Reset, then branch at pc 0x40, ghr 0 -> pred_index 0x00, pred_taken 0, pred_ghr 0.
REQ-033 Two resolved taken branches at res_index 0x05 -> PHT[5] 01->10->11; lookup at index 5 gives pred_taken 1; third taken keeps 11.
REQ-034 Three fetched branches predicted 0,0,1 with no stall -> ghr_q 5'b00001; with fetch_stall=1 on the third -> ghr_q 5'b00000.
REQ-035 Same cycle: fetch shift (pred 1) and mispredict with res_ghr 5'b10110, res_taken 0 -> ghr_q 5'b01100.
REQ-036 Same-cycle lookup/update at index 0x0A with PHT 01, res_taken 1 -> pred_taken 0 this cycle, 1 next cycle.
REQ-037 reset_n asserted mid-sequence after 4 branches / 2 mispredicts -> stat counters 0, all PHT 01 immediately without clock edge.
